// File: rtl/rtlmem_rdq.sv
// Read-request queue in front of a 2-cycle-latency memory read port.
// Credits bound outstanding reads so the response FIFO can never overflow.
`timescale 1ns/1ps
module rtlmem_rdq #(
   parameter int G_ADDR  = 10,
   parameter int G_WIDTH = 16,
   parameter int G_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_vld,
   input  logic [G_ADDR-1:0]          req_addr,
   output logic                       req_rdy,
   output logic                       memre,
   output logic [G_ADDR-1:0]          memra,
   input  logic [G_WIDTH-1:0]         memdo,
   output logic                       rsp_vld,
   output logic [G_WIDTH-1:0]         rsp_dat,
   input  logic                       rsp_rdy,
   output logic [$clog2(G_DEPTH):0]   inflight
);

   localparam int PW = $clog2(G_DEPTH);
   localparam int CW = PW + 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and rsp_vld holds until consumed.

   logic [CW-1:0]      cnt;
   logic               re_d1;
   logic               re_d2;
   logic [G_WIDTH-1:0] fifo_mem [G_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               full_bit;
   logic               fifo_empty;
   logic               fifo_wr;
   logic               fifo_rd;
   logic               accept;

   // Credits cover both the memory pipeline and the FIFO, so ready only
   // looks at the counter and never at rsp_rdy.
   assign req_rdy    = !rst && (cnt < CW'(G_DEPTH));
   assign accept     = req_vld && req_rdy;
   assign memre      = accept;
   assign memra      = req_addr;

   assign fifo_empty = (wr_ptr == rd_ptr) && !full_bit;
   assign fifo_wr    = re_d2;
   assign rsp_vld    = !rst && !fifo_empty;
   assign fifo_rd    = rsp_vld && rsp_rdy;
   assign rsp_dat    = rsp_vld ? fifo_mem[rd_ptr] : '0;
   assign inflight   = rst ? '0 : cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         re_d1    <= 1'b0;
         re_d2    <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         full_bit <= 1'b0;
      end else begin
         re_d1 <= accept;
         re_d2 <= re_d1;

         unique case ({accept, fifo_rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase

         if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);

         // Pointers alone cannot tell full from empty when they are equal.
         if (fifo_wr && !fifo_rd && ((wr_ptr + PW'(1)) == rd_ptr))
            full_bit <= 1'b1;
         else if (fifo_rd && !fifo_wr)
            full_bit <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && fifo_wr)
         fifo_mem[wr_ptr] <= memdo;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_wr && full_bit && !fifo_rd));

   a_credit_bound: assert property (@(posedge clk) disable iff (rst)
      cnt <= CW'(G_DEPTH));

endmodule
